// File: rtl/calc_sequencer.sv
// Calculator sequencer: builds two decimal operands from key events, launches
// one ALU operation at a time and owns the displayed value and error flag.
module calc_sequencer #(
  parameter int MAX_MAG = 32767
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               KeyRdy,
  output logic               KeyRd,
  input  logic [3:0]         keypad_input,
  input  logic [2:0]         operator_input,
  input  logic               equal_input,
  output logic               alu_start,
  output logic [2:0]         alu_op,
  output logic signed [15:0] alu_a,
  output logic signed [15:0] alu_b,
  input  logic               alu_done,
  input  logic signed [15:0] alu_result,
  input  logic               alu_err,
  output logic signed [15:0] disp_value,
  output logic               disp_err
);

  typedef enum logic [2:0] {
    S_A      = 3'd0,
    S_OP     = 3'd1,
    S_B      = 3'd2,
    S_EXEC   = 3'd3,
    S_RESULT = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } alu_req_t;

  state_t      state_q, state_d;
  logic [15:0] acc_a_q, acc_a_d;
  logic [15:0] acc_b_q, acc_b_d;
  logic [2:0]  op_q, op_d;
  logic [2:0]  next_op_q, next_op_d;
  logic        keyrd_q, keyrd_d;
  logic        guard_q, guard_d;
  logic        start_q, start_d;
  alu_req_t    req_q, req_d;

  logic        accept;
  logic        is_eq, is_dig, is_op, is_clr, is_neg;
  logic [16:0] app_a, app_b;
  logic [15:0] neg_a, neg_b;

  // Returns {fits, value}; the sign of acc is kept and digits grow the magnitude.
  function automatic logic [16:0] digit_append(input logic [15:0] acc,
                                               input logic [3:0]  d);
    logic [16:0] mag;
    logic [20:0] nm;
    logic [15:0] val;
    mag = acc[15] ? (17'd0 - {1'b1, acc}) : {1'b0, acc};
    nm  = {4'd0, mag} * 21'd10 + {17'd0, d};
    val = acc[15] ? (16'd0 - nm[15:0]) : nm[15:0];
    return {(nm <= 21'(MAX_MAG)), val};
  endfunction

  // -32768 has no positive counterpart, so it negates to itself.
  function automatic logic [15:0] negate(input logic [15:0] v);
    return (v == 16'h8000) ? v : (16'd0 - v);
  endfunction

  assign app_a = digit_append(acc_a_q, keypad_input);
  assign app_b = digit_append(acc_b_q, keypad_input);
  assign neg_a = negate(acc_a_q);
  assign neg_b = negate(acc_b_q);

  assign is_eq  = equal_input;
  assign is_dig = !equal_input && (operator_input == 3'b000);
  assign is_op  = !equal_input && (operator_input >= 3'b001) && (operator_input <= 3'b100);
  assign is_clr = !equal_input && (operator_input == 3'b101);
  assign is_neg = !equal_input && (operator_input == 3'b110);

  // guard trails KeyRd by one cycle so a KeyRdy not yet dropped is not re-taken.
  assign accept = KeyRdy && !keyrd_q && !guard_q && (state_q != S_EXEC);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_A;
      acc_a_q   <= '0;
      acc_b_q   <= '0;
      op_q      <= '0;
      next_op_q <= '0;
      keyrd_q   <= 1'b0;
      guard_q   <= 1'b0;
      start_q   <= 1'b0;
      req_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_a_q   <= acc_a_d;
      acc_b_q   <= acc_b_d;
      op_q      <= op_d;
      next_op_q <= next_op_d;
      keyrd_q   <= keyrd_d;
      guard_q   <= guard_d;
      start_q   <= start_d;
      req_q     <= req_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_a_d   = acc_a_q;
    acc_b_d   = acc_b_q;
    op_d      = op_q;
    next_op_d = next_op_q;
    keyrd_d   = 1'b0;
    guard_d   = keyrd_q;
    start_d   = 1'b0;
    req_d     = req_q;

    if (state_q == S_EXEC) begin
      // done in the launch cycle itself is too early to be a real answer
      if (alu_done && !start_q) begin
        if (alu_err) begin
          state_d = S_ERR;
        end else begin
          acc_a_d = alu_result;
          if (next_op_q != 3'd0) begin
            op_d    = next_op_q;
            state_d = S_OP;
          end else begin
            state_d = S_RESULT;
          end
        end
      end
    end else if (accept) begin
      keyrd_d = 1'b1;
      if (is_clr) begin
        acc_a_d = '0;
        acc_b_d = '0;
        op_d    = '0;
        state_d = S_A;
      end else begin
        unique case (state_q)
          S_A: begin
            if (is_dig && app_a[16]) acc_a_d = app_a[15:0];
            else if (is_neg)         acc_a_d = neg_a;
            else if (is_op) begin
              op_d    = operator_input;
              state_d = S_OP;
            end
          end
          S_OP: begin
            if (is_dig) begin
              acc_b_d = {12'd0, keypad_input};
              state_d = S_B;
            end else if (is_op) begin
              op_d = operator_input;
            end
          end
          S_B: begin
            if (is_dig && app_b[16]) acc_b_d = app_b[15:0];
            else if (is_neg)         acc_b_d = neg_b;
            else if (is_eq || is_op) begin
              start_d   = 1'b1;
              req_d     = '{op: op_q, a: acc_a_q, b: acc_b_q};
              next_op_d = is_op ? operator_input : 3'd0;
              state_d   = S_EXEC;
            end
          end
          S_RESULT: begin
            if (is_dig) begin
              acc_a_d = {12'd0, keypad_input};
              state_d = S_A;
            end else if (is_neg) begin
              acc_a_d = neg_a;
            end else if (is_op) begin
              op_d    = operator_input;
              state_d = S_OP;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    disp_value = acc_a_q;
    disp_err   = 1'b0;
    if (state_q == S_B) begin
      disp_value = acc_b_q;
    end else if (state_q == S_ERR) begin
      disp_value = '0;
      disp_err   = 1'b1;
    end
  end

  assign KeyRd     = keyrd_q;
  assign alu_start = start_q;
  assign alu_op    = req_q.op;
  assign alu_a     = req_q.a;
  assign alu_b     = req_q.b;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: key-sequence table with hand-computed
// display values, plus busy-ALU, overflow and mid-operation reset sequences.
module tb_calc_sequencer;

  localparam logic [2:0] KD = 3'd0, ADD = 3'd1, SUB = 3'd2, MUL = 3'd3,
                         DIV = 3'd4, CLR = 3'd5, NEG = 3'd6, IGN = 3'd7;

  logic        clk, nRST, KeyRdy, KeyRd, equal_input;
  logic [3:0]  keypad_input;
  logic [2:0]  operator_input, alu_op;
  logic        alu_start, alu_done, alu_err, disp_err;
  logic [15:0] alu_a, alu_b, alu_result, disp_value;

  calc_sequencer dut (
    .clk(clk), .nRST(nRST), .KeyRdy(KeyRdy), .KeyRd(KeyRd),
    .keypad_input(keypad_input), .operator_input(operator_input),
    .equal_input(equal_input), .alu_start(alu_start), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done),
    .alu_result(alu_result), .alu_err(alu_err),
    .disp_value(disp_value), .disp_err(disp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  opc;
    logic [3:0]  d;
    logic        eq;
    logic [15:0] disp;
    logic        err;
  } vec_t;

  vec_t        tv[$];
  logic [15:0] la_h[$], lb_h[$];
  logic [2:0]  lop_h[$];
  int          n_chk = 0, n_err = 0;
  int          alu_delay = 2;
  int          done_cnt = 0;
  int          rd_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] opc, input logic [3:0] d, input logic eq,
                     input logic [15:0] disp, input logic err);
    vec_t v;
    v.opc = opc; v.d = d; v.eq = eq; v.disp = disp; v.err = err;
    tv.push_back(v);
  endtask

  task automatic press(input logic [2:0] opc, input logic [3:0] d, input logic eq,
                       input int settle);
    bit got;
    got = 0;
    operator_input = opc; keypad_input = d; equal_input = eq; KeyRdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (KeyRd) begin got = 1; break; end
    end
    chk("key_ack", 32'(got), 32'd1);
    KeyRdy = 1'b0;
    repeat (settle) @(negedge clk);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      press(tv[i].opc, tv[i].d, tv[i].eq, alu_delay + 4);
      chk($sformatf("row%0d_disp", i), 32'(disp_value), 32'(tv[i].disp));
      chk($sformatf("row%0d_err", i), 32'(disp_err), 32'(tv[i].err));
    end
  endtask

  always @(negedge clk) if (KeyRd) rd_cnt++;

  // Behavioural ALU: answers each launch after alu_delay cycles.
  initial begin
    logic [15:0] la, lb;
    logic [2:0]  lop;
    int          a, b, r;
    bit          e, aborted;
    alu_done = 1'b0; alu_result = '0; alu_err = 1'b0;
    forever begin
      @(negedge clk);
      if (alu_start === 1'b1) begin
        la = alu_a; lb = alu_b; lop = alu_op; aborted = 0;
        la_h.push_back(la); lb_h.push_back(lb); lop_h.push_back(lop);
        for (int i = 0; i < alu_delay - 1; i++) begin
          @(negedge clk);
          if (!nRST) aborted = 1;
        end
        a = int'($signed(la)); b = int'($signed(lb)); e = 0; r = 0;
        case (lop)
          3'd1: r = a + b;
          3'd2: r = a - b;
          3'd3: r = a * b;
          3'd4: if (b == 0) e = 1; else r = a / b;
          default: e = 1;
        endcase
        if (r > 32767 || r < -32768) e = 1;
        if (!aborted) begin
          chk("alu_a_hold", 32'(alu_a), 32'(la));
          chk("alu_b_hold", 32'(alu_b), 32'(lb));
          chk("alu_op_hold", 32'(alu_op), 32'(lop));
        end
        alu_result = 16'(r); alu_err = e; alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0; alu_err = 1'b0;
        done_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int r0, d0, busy_viol, busy_cyc;
    bit got;
    nRST = 1'b0; KeyRdy = 1'b0; keypad_input = '0; operator_input = '0; equal_input = 1'b0;

    add(KD,1,0,16'd1,0);  add(KD,2,0,16'd12,0); add(ADD,0,0,16'd12,0);
    add(KD,3,0,16'd3,0);  add(KD,4,0,16'd34,0); add(KD,0,1,16'd46,0);          // 0-5
    add(KD,7,0,16'd7,0);  add(SUB,0,0,16'd7,0); add(KD,9,0,16'd9,0);
    add(KD,0,1,16'hFFFE,0); add(KD,5,0,16'd5,0); add(CLR,0,0,16'd0,0);         // 6-11
    add(KD,2,0,16'd2,0);  add(MUL,0,0,16'd2,0); add(KD,3,0,16'd3,0);
    add(ADD,0,0,16'd6,0); add(KD,4,0,16'd4,0);  add(KD,0,1,16'd10,0);          // 12-17
    add(CLR,0,0,16'd0,0); add(KD,3,0,16'd3,0);  add(KD,2,0,16'd32,0);
    add(KD,7,0,16'd327,0); add(KD,6,0,16'd3276,0); add(KD,7,0,16'h7FFF,0);     // 18-23
    add(NEG,0,0,16'h8001,0); add(SUB,0,0,16'h8001,0); add(KD,1,0,16'd1,0);
    add(KD,0,1,16'h8000,0); add(NEG,0,0,16'h8000,0); add(IGN,0,0,16'h8000,0);  // 24-29
    add(KD,0,1,16'h8000,0); add(CLR,0,0,16'd0,0); add(KD,5,0,16'd5,0);
    add(DIV,0,0,16'd5,0); add(KD,0,0,16'd0,0);  add(KD,0,1,16'd0,1);           // 30-35
    add(KD,1,0,16'd0,1);  add(ADD,0,0,16'd0,1); add(CLR,0,0,16'd0,0);
    add(KD,8,0,16'd8,0);  add(MUL,0,0,16'd8,0); add(SUB,0,0,16'd8,0);          // 36-41
    add(NEG,0,0,16'd8,0); add(KD,3,0,16'd3,0);  add(KD,0,1,16'd5,0);           // 42-44

    repeat (3) @(negedge clk);
    chk("rst_keyrd", 32'(KeyRd), 0);     chk("rst_start", 32'(alu_start), 0);
    chk("rst_op", 32'(alu_op), 0);       chk("rst_a", 32'(alu_a), 0);
    chk("rst_b", 32'(alu_b), 0);         chk("rst_disp", 32'(disp_value), 0);
    chk("rst_err", 32'(disp_err), 0);
    nRST = 1'b1;
    @(negedge clk);

    run_rows(0, 5);
    chk("n_launch", 32'(la_h.size()), 1);
    chk("l0_a", 32'(la_h[0]), 12); chk("l0_b", 32'(lb_h[0]), 34); chk("l0_op", 32'(lop_h[0]), 1);
    run_rows(6, 17);
    chk("l2_a", 32'(la_h[2]), 2);  chk("l2_b", 32'(lb_h[2]), 3);  chk("l2_op", 32'(lop_h[2]), 3);
    chk("l3_a", 32'(la_h[3]), 6);  chk("l3_b", 32'(lb_h[3]), 4);  chk("l3_op", 32'(lop_h[3]), 1);
    run_rows(18, tv.size() - 1);
    chk("l6_op", 32'(lop_h[6]), 2);

    // digit that would overflow is still acknowledged
    press(CLR, 0, 0, 3);
    r0 = rd_cnt;
    press(KD,3,0,3); press(KD,2,0,3); press(KD,7,0,3); press(KD,6,0,3); press(KD,8,0,3);
    chk("ovf_pulses", 32'(rd_cnt - r0), 5);
    chk("ovf_disp", 32'(disp_value), 3276);
    press(NEG, 0, 0, 3);
    chk("ovf_neg", 32'(disp_value), 32'(16'hF334));

    // keys held off while the ALU is slow
    press(CLR, 0, 0, 3);
    alu_delay = 20;
    press(KD,1,0,3); press(ADD,0,0,3); press(KD,2,0,3);
    operator_input = KD; keypad_input = 0; equal_input = 1'b1; KeyRdy = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (KeyRd) begin got = 1; break; end
    end
    chk("busy_eq_ack", 32'(got), 1);
    equal_input = 1'b0; keypad_input = 4'd9;
    d0 = done_cnt; busy_viol = 0; busy_cyc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_cnt != d0) break;
      busy_cyc++;
      if (KeyRd) busy_viol++;
    end
    chk("busy_no_keyrd", 32'(busy_viol), 0);
    chk("busy_long", 32'(busy_cyc >= 18), 1);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      if (KeyRd) begin got = 1; break; end
      @(negedge clk);
    end
    chk("busy_keyrd_after", 32'(got), 1);
    KeyRdy = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_disp", 32'(disp_value), 9);

    // asynchronous reset while the ALU is busy
    press(CLR, 0, 0, 4);
    press(KD,1,0,3); press(ADD,0,0,3); press(KD,2,0,3);
    press(KD,0,1,3);
    #1 nRST = 1'b0;
    #2;
    chk("ar_keyrd", 32'(KeyRd), 0);  chk("ar_start", 32'(alu_start), 0);
    chk("ar_op", 32'(alu_op), 0);    chk("ar_a", 32'(alu_a), 0);
    chk("ar_b", 32'(alu_b), 0);      chk("ar_disp", 32'(disp_value), 0);
    chk("ar_err", 32'(disp_err), 0);
    @(negedge clk);
    #1 nRST = 1'b1;
    repeat (30) @(negedge clk);
    chk("stray_disp", 32'(disp_value), 0);
    chk("stray_err", 32'(disp_err), 0);
    press(KD, 4, 0, 4);
    chk("post_rst_disp", 32'(disp_value), 4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Top-level sequencer for the 16-bit signed calculator. It consumes debounced key events from the keypad front end through the KeyRdy/KeyRd handshake and builds two decimal operands. It issues one operation at a time to the arithmetic unit through a start/done handshake and drives the value shown on the display. It sits between the keypad input controller and the ALU and owns all calculator state.

## Interface
- MAX_MAG, 32767: largest operand magnitude accepted during digit entry.
- clk  in  1  system clock; every register updates on the rising edge.
- nRST  in  1  reset, asynchronous and active-low.
- KeyRdy  in  1  key event pending; held high until acknowledged.
- KeyRd  out  1  key acknowledge, one-cycle pulse.
- keypad_input  in  4  digit value 0–9; valid only when KeyRdy=1.
- operator_input  in  3  operator code: 000 digit/none, 001 add, 010 sub, 011 mul, 100 div, 101 clear, 110 negate, 111 ignored.
- equal_input  in  1  '=' key; takes priority over operator_input.
- alu_start  out  1  one-cycle launch pulse.
- alu_op  out  3  operation code, 001–100.
- alu_a, alu_b  out  16  signed operands.
- alu_done  in  1  result valid, one-cycle pulse.
- alu_result  in  16  signed result.
- alu_err  in  1  qualifies alu_done; divide by zero or overflow.
- disp_value  out  16  signed value to display.
- disp_err  out  1  error indicator.

## Operation
- States: S_A (entering A), S_OP (operator latched, B empty), S_B (entering B), S_EXEC (ALU busy), S_RESULT, S_ERR.
- Key classes:
  - equal_input=1 is EQ.
  - Otherwise operator_input=000 is DIGIT, 001–100 is OP, 101 is CLR, 110 is NEG, 111 is consumed with no effect.
- Digit append: new = sign(acc)·(|acc|·10 + d).
  - The digit is applied only if the new magnitude ≤ MAX_MAG.
  - Otherwise the key is consumed and acc is unchanged.
- CLR from any state except S_EXEC: acc_a=acc_b=0, op=0, go to S_A.
- S_A:
  - DIGIT: append to acc_a.
  - NEG: acc_a = −acc_a.
  - OP: latch op, go to S_OP.
  - EQ: no effect.
- S_OP:
  - DIGIT: acc_b=d, go to S_B.
  - OP: replace op.
  - NEG and EQ: no effect.
- S_B:
  - DIGIT: append to acc_b.
  - NEG: acc_b = −acc_b.
  - EQ: launch with next_op=0.
  - OP: launch with next_op equal to the new code (chaining).
- S_EXEC:
  - Keys are not accepted; KeyRdy is left pending.
  - On alu_done with alu_err=1: go to S_ERR.
  - Otherwise acc_a=alu_result, then go to S_OP with op=next_op if next_op≠0, else to S_RESULT.
- S_RESULT:
  - DIGIT: acc_a=d, go to S_A.
  - NEG: negate acc_a.
  - OP: latch op, go to S_OP.
  - EQ: no effect.
- S_ERR: only CLR exits; every other key is acknowledged and ignored.
- Negating −32768 leaves it unchanged.
- Display:
  - disp_value = acc_b in S_B, 0 in S_ERR, acc_a otherwise.
  - disp_err = 1 only in S_ERR.

## Timing
- Reset values: state S_A; acc_a, acc_b, op and next_op all 0. Outputs: KeyRd=0, alu_start=0, alu_op=0, alu_a=0, alu_b=0, disp_value=0, disp_err=0.
- Key accept condition: the edge samples KeyRdy=1, KeyRd=0, guard=0, and state≠S_EXEC.
- On accept:
  - KeyRd is high for exactly the following cycle.
  - Accumulator and state updates are visible in that same cycle.
- guard is set in the KeyRd cycle, which blocks re-acceptance of a stale KeyRdy. Minimum spacing between accepts is 3 cycles.
- Launch:
  - alu_start is high in the same cycle as KeyRd for the triggering EQ/OP.
  - alu_a=acc_a, alu_b=acc_b and alu_op=op are registered at that edge.
  - alu_a, alu_b and alu_op are held stable until the cycle after alu_done.
- alu_done is honoured no earlier than the cycle after alu_start. The result and state are visible the cycle after alu_done.
- KeyRdy and alu_done both high while in S_EXEC: alu_done is processed and the key is accepted at the next eligible edge.
- nRST asserted mid-S_EXEC: immediate return to reset values. A later stray alu_done in S_A is ignored.

## Test plan
- Keys 1,2,+,3,4,= → disp_value 12, 12, 34, then 46 in S_RESULT. Exactly one alu_start with a=12, b=34, op=001.
- Keys 7,−,9,= (ALU returns −2) → disp_value 0xFFFE, disp_err=0. Then key 5 → disp_value 5, state S_A.
- Chaining: keys 2,*,3,+,4,= → first launch op=011 a=2 b=3. On done, state S_OP with op=001. Second launch a=6 b=4; final value 10.
- Overflow: keys 3,2,7,6,8 → disp_value 3276, and five KeyRd pulses. Then NEG → −3276.
- Error: keys 5,/,0,= with the ALU returning alu_err → disp_err=1 and disp_value 0. Keys 1,+ are acknowledged and ignored; CLR returns to S_A with 0.
- Busy path: with the ALU holding alu_done off for 20 cycles and KeyRdy high, KeyRd stays 0 throughout S_EXEC. It pulses after done. A second test pulses nRST mid-S_EXEC → all outputs reach reset values with no clock edge needed.
